// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and the round-robin ring helper for the write-back arbiter.
// The ring helper is kept here so other port arbiters can reuse it.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;

    // Index that follows idx in a ring of n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of write-back requests, decode hazard query and register-file write port.
// The master side is the pipeline (execute/memory/decode); the slave side is the arbiter.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_REQ = 3
);

    // Handshake: requester k transfers when i_req_valid[k] & o_req_ready[k] at a
    // rising edge. A requester that sees ready=0 holds valid, rd and data stable.
    logic [N_REQ-1:0]            i_req_valid;
    logic [REG_ADDR_W*N_REQ-1:0] i_req_rd;
    logic [WIDTH*N_REQ-1:0]      i_req_data;
    logic [N_REQ-1:0]            o_req_ready;

    logic                        i_issue_valid;
    logic [REG_ADDR_W-1:0]       i_issue_rd;

    logic [REG_ADDR_W-1:0]       i_rs1;
    logic [REG_ADDR_W-1:0]       i_rs2;
    logic                        o_stall;

    logic                        o_regwrite;
    logic [REG_ADDR_W-1:0]       o_rd;
    logic [WIDTH-1:0]            o_write_data;
    logic [NUM_REGS-1:0]         o_pending;

    modport master (
        output i_req_valid, i_req_rd, i_req_data,
        output i_issue_valid, i_issue_rd,
        output i_rs1, i_rs2,
        input  o_req_ready, o_stall,
        input  o_regwrite, o_rd, o_write_data, o_pending
    );

    modport slave (
        input  i_req_valid, i_req_rd, i_req_data,
        input  i_issue_valid, i_issue_rd,
        input  i_rs1, i_rs2,
        output o_req_ready, o_stall,
        output o_regwrite, o_rd, o_write_data, o_pending
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting one past ptr, wrapping,
// and grants the first set bit. Grant is one-hot or zero.
module rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_valid
);

    int idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = rr_next(int'(ptr), N);
        for (int i = 0; i < N; i++) begin
            if (!grant_valid && req[idx[PTR_W-1:0]]) begin
                grant[idx[PTR_W-1:0]] = 1'b1;
                grant_idx             = idx[PTR_W-1:0];
                grant_valid           = 1'b1;
            end
            idx = rr_next(idx, N);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between N_REQ write-back units, tracks pending
// long-latency destinations and flags decode RAW hazards on pending or in-flight writes.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_REQ = 3
) (
    input  logic                clk,
    input  logic                s_reset,
    regfile_wb_arbiter_if.slave bus
);

    localparam int               PTR_W     = $clog2(N_REQ);
    localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(N_REQ - 1);

    logic [N_REQ-1:0]      grant;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic [REG_ADDR_W-1:0] grant_rd;
    logic [WIDTH-1:0]      grant_data;

    logic [PTR_W-1:0]      rr_ptr_q,   rr_ptr_d;
    logic                  regwrite_q, regwrite_d;
    logic [REG_ADDR_W-1:0] rd_q,       rd_d;
    logic [WIDTH-1:0]      data_q,     data_d;
    logic [NUM_REGS-1:0]   pending_q,  pending_d;

    logic                  hit_rs1;
    logic                  hit_rs2;

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req         (bus.i_req_valid),
        .ptr         (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        grant_rd   = '0;
        grant_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                grant_rd   = bus.i_req_rd[REG_ADDR_W*k +: REG_ADDR_W];
                grant_data = bus.i_req_data[WIDTH*k +: WIDTH];
            end
        end
    end

    // A grant to x0 still completes the handshake and moves the pointer, but never
    // writes and never touches the scoreboard. An issue in the same cycle as the
    // clear of the same register wins, since it belongs to a younger instruction.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        data_d     = data_q;
        pending_d  = pending_q;
        if (grant_valid) begin
            rr_ptr_d   = grant_idx;
            regwrite_d = (grant_rd != '0);
            rd_d       = grant_rd;
            data_d     = grant_data;
            if (grant_rd != '0) begin
                pending_d[grant_rd] = 1'b0;
            end
        end
        if (bus.i_issue_valid && (bus.i_issue_rd != '0)) begin
            pending_d[bus.i_issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (s_reset) begin
            rr_ptr_q   <= PTR_RESET;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
            pending_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            pending_q  <= pending_d;
        end
    end

    // The write sitting on the port this cycle is not yet readable from the file.
    always_comb begin
        hit_rs1 = (bus.i_rs1 != '0) &&
                  (pending_q[bus.i_rs1] || (regwrite_q && (rd_q == bus.i_rs1)));
        hit_rs2 = (bus.i_rs2 != '0) &&
                  (pending_q[bus.i_rs2] || (regwrite_q && (rd_q == bus.i_rs2)));
    end

    assign bus.o_req_ready  = grant;
    assign bus.o_stall      = hit_rs1 | hit_rs2;
    assign bus.o_regwrite   = regwrite_q;
    assign bus.o_rd         = rd_q;
    assign bus.o_write_data = data_q;
    assign bus.o_pending    = pending_q;

endmodule
